// File: rtl/change_event_sched_if.sv
// Event port between change_event_sched (master) and a single consumer (slave).
interface change_event_sched_if #(
    parameter int N_CH = 4,
    parameter int DW   = 2,
    parameter int TSW  = 16
);
    localparam int CW = $clog2(N_CH);

    logic           evt_valid;
    logic           evt_ready;
    logic [CW-1:0]  evt_ch;
    logic [DW-1:0]  evt_old;
    logic [DW-1:0]  evt_new;
    logic [TSW-1:0] evt_time;

    modport master (
        output evt_valid, evt_ch, evt_old, evt_new, evt_time,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_ch, evt_old, evt_new, evt_time,
        output evt_ready
    );
endinterface

// File: rtl/change_event_sched.sv
// Change-event scheduler: captures per-channel value changes and serializes them round-robin.
// Define CES_INIT_EVENT_EN to report nonzero channels on the first cycle after reset.
module change_event_sched #(
    parameter int N_CH = 4,
    parameter int DW   = 2,
    parameter int TSW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH*DW-1:0]   ch_data,
    input  logic [N_CH-1:0]      ch_mask,
    output logic [N_CH-1:0]      ovf,
    input  logic                 ovf_clr,
    change_event_sched_if.master evt
);
    localparam int CW = $clog2(N_CH);

    typedef enum logic {IDLE, SHOW} state_t;
    state_t state, state_nx;

    logic [DW-1:0]   prev      [N_CH];
    logic [DW-1:0]   slot_old  [N_CH];
    logic [DW-1:0]   slot_new  [N_CH];
    logic [TSW-1:0]  slot_time [N_CH];
    logic [N_CH-1:0] pend;
    logic [TSW-1:0]  ts;
    logic [CW-1:0]   last;

    logic [N_CH-1:0] watch_chg, chg, take, set_ovf, req, above, hi, pick;
    logic [CW-1:0]   base, grant_ch;
    logic            accept, grant_any, load;

    always_comb begin
        watch_chg = '0;
        for (int i = 0; i < N_CH; i++)
            watch_chg[i] = ch_mask[i] && (ch_data[i*DW +: DW] != prev[i]);
    end

`ifdef CES_INIT_EVENT_EN
    assign chg = watch_chg;
`else
    // The first edge after reset only records the baseline into prev.
    logic base_done;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) base_done <= 1'b0;
        else        base_done <= 1'b1;
    end
    assign chg = base_done ? watch_chg : '0;
`endif

    assign accept  = (state == SHOW) && evt.evt_ready;
    assign take    = accept ? (N_CH'(1) << evt.evt_ch) : '0;
    assign set_ovf = chg & pend & ~take;

    // Round-robin: prefer requesters above the last grant, else wrap to the lowest one.
    always_comb begin
        base     = accept ? evt.evt_ch : last;
        req      = pend & ~take;
        above    = '0;
        for (int i = 0; i < N_CH; i++)
            above[i] = (i > int'(base));
        hi        = req & above;
        pick      = (|hi) ? hi : req;
        grant_any = |req;
        grant_ch  = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (pick[i]) grant_ch = CW'(i);
    end

    assign load = grant_any && ((state == IDLE) || accept);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_any) state_nx = SHOW;
            SHOW:    if (accept)    state_nx = grant_any ? SHOW : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    assign evt.evt_valid = (state == SHOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last         <= CW'(N_CH - 1);
            evt.evt_ch   <= '0;
            evt.evt_old  <= '0;
            evt.evt_new  <= '0;
            evt.evt_time <= '0;
        end else begin
            if (accept) last <= evt.evt_ch;
            if (load) begin
                evt.evt_ch   <= grant_ch;
                evt.evt_old  <= slot_old[grant_ch];
                evt.evt_new  <= slot_new[grant_ch];
                evt.evt_time <= slot_time[grant_ch];
            end
        end
    end

    // A change on the channel being accepted starts a fresh event from the delivered value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts   <= '0;
            pend <= '0;
            ovf  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                prev[i]      <= '0;
                slot_old[i]  <= '0;
                slot_new[i]  <= '0;
                slot_time[i] <= '0;
            end
        end else begin
            ts <= ts + 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                prev[i] <= ch_data[i*DW +: DW];
                if (set_ovf[i]) begin
                    slot_new[i] <= ch_data[i*DW +: DW];
                end else if (chg[i]) begin
                    pend[i]      <= 1'b1;
                    slot_old[i]  <= take[i] ? evt.evt_new : prev[i];
                    slot_new[i]  <= ch_data[i*DW +: DW];
                    slot_time[i] <= ts;
                end else if (take[i]) begin
                    pend[i] <= 1'b0;
                end
                if (set_ovf[i])   ovf[i] <= 1'b1;
                else if (ovf_clr) ovf[i] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_change_event_sched.sv
// Randomized and directed bench for change_event_sched against an event-level reference model.
module tb_change_event_sched;
    localparam int N_CH = 4;
    localparam int DW   = 2;
    localparam int TSW  = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_CH*DW-1:0]  ch_data;
    logic [N_CH-1:0]     ch_mask;
    logic [N_CH-1:0]     ovf;
    logic                ovf_clr;

    change_event_sched_if #(.N_CH(N_CH), .DW(DW), .TSW(TSW)) evt_if ();

    change_event_sched #(.N_CH(N_CH), .DW(DW), .TSW(TSW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ch_data (ch_data),
        .ch_mask (ch_mask),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .evt     (evt_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {int ch; int old_v; int new_v; int tm;} ev_t;
    ev_t obs_q[$];

    // Reference model: one pending slot per channel plus the currently presented event.
    int m_prev[N_CH], m_old[N_CH], m_new[N_CH], m_time[N_CH];
    bit m_pend[N_CH], m_ovf[N_CH];
    int m_ts, m_last, m_ch, m_oold, m_onew, m_otime;
    bit m_show, m_first;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int chVal(input logic [N_CH*DW-1:0] v, input int i);
        return int'(v[i*DW +: DW]);
    endfunction

    function automatic logic [N_CH*DW-1:0] withCh(input logic [N_CH*DW-1:0] v, input int i, input int val);
        v[i*DW +: DW] = DW'(val);
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N_CH; i++) begin
            m_prev[i] = 0; m_old[i] = 0; m_new[i] = 0; m_time[i] = 0;
            m_pend[i] = 0; m_ovf[i] = 0;
        end
        m_ts = 0; m_last = N_CH - 1; m_ch = 0; m_oold = 0; m_onew = 0; m_otime = 0;
        m_show = 0; m_first = 1;
    endtask

    task automatic modelEdge();
        bit accepted, c, taking, setovf;
        int acc, acc_new, start, win, d;
        accepted = m_show && evt_if.evt_ready;
        acc      = m_ch;
        acc_new  = m_onew;
        win      = -1;
        start    = accepted ? acc : m_last;
        for (int k = 1; k <= N_CH; k++) begin
            int j;
            j = (start + k) % N_CH;
            if (win < 0 && m_pend[j] && !(accepted && j == acc)) win = j;
        end
        if (accepted) m_last = acc;
        if (!m_show || accepted) begin
            if (win >= 0) begin
                m_show = 1; m_ch = win;
                m_oold = m_old[win]; m_onew = m_new[win]; m_otime = m_time[win];
            end else begin
                m_show = 0;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            d = chVal(ch_data, i);
            c = ch_mask[i] && (d != m_prev[i]);
`ifndef CES_INIT_EVENT_EN
            if (m_first) c = 0;
`endif
            taking = accepted && (i == acc);
            if (taking) m_pend[i] = 0;
            setovf = 0;
            if (c) begin
                if (m_pend[i]) begin
                    m_new[i] = d;
                    setovf   = 1;
                end else begin
                    m_pend[i] = 1;
                    m_old[i]  = taking ? acc_new : m_prev[i];
                    m_new[i]  = d;
                    m_time[i] = m_ts;
                end
            end
            if (setovf)       m_ovf[i] = 1;
            else if (ovf_clr) m_ovf[i] = 0;
            m_prev[i] = d;
        end
        m_ts    = (m_ts + 1) % (1 << TSW);
        m_first = 0;
    endtask

    task automatic checkAll();
        logic [N_CH-1:0] e;
        for (int i = 0; i < N_CH; i++) e[i] = m_ovf[i];
        checkOutput("evt_valid", 32'(evt_if.evt_valid), 32'(m_show));
        if (m_show) begin
            checkOutput("evt_ch",   32'(evt_if.evt_ch),   32'(m_ch));
            checkOutput("evt_old",  32'(evt_if.evt_old),  32'(m_oold));
            checkOutput("evt_new",  32'(evt_if.evt_new),  32'(m_onew));
            checkOutput("evt_time", 32'(evt_if.evt_time), 32'(m_otime));
        end
        checkOutput("ovf", 32'(ovf), 32'(e));
    endtask

    // Called at a falling edge: drive inputs, log an accept, clock once, then compare.
    task automatic applyStimulus(input logic [N_CH*DW-1:0] data, input logic [N_CH-1:0] mask,
                                 input logic rdy, input logic clr);
        ev_t ev;
        ch_data          = data;
        ch_mask          = mask;
        evt_if.evt_ready = rdy;
        ovf_clr          = clr;
        if (evt_if.evt_valid && rdy) begin
            ev.ch = int'(evt_if.evt_ch); ev.old_v = int'(evt_if.evt_old);
            ev.new_v = int'(evt_if.evt_new); ev.tm = int'(evt_if.evt_time);
            obs_q.push_back(ev);
        end
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_valid", 32'(evt_if.evt_valid), 32'd0);
        checkOutput("rst_ch",    32'(evt_if.evt_ch),    32'd0);
        checkOutput("rst_old",   32'(evt_if.evt_old),   32'd0);
        checkOutput("rst_new",   32'(evt_if.evt_new),   32'd0);
        checkOutput("rst_time",  32'(evt_if.evt_time),  32'd0);
        checkOutput("rst_ovf",   32'(ovf),              32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N_CH*DW-1:0] cur;
        logic [N_CH-1:0]    mask;
        int                 tfirst, exp_cnt;

        rst_n = 1'b1; ch_data = '0; ch_mask = '0; ovf_clr = 1'b0; evt_if.evt_ready = 1'b0;
        @(negedge clk);
        doReset();

        // Single change on channel 1 sampled at ts=10.
        cur = '0;
        for (int k = 0; k < 10; k++) applyStimulus(cur, 4'hF, 1'b1, 1'b0);
        cur = withCh(cur, 1, 1);
        obs_q.delete();
        for (int k = 0; k < 5; k++) applyStimulus(cur, 4'hF, 1'b1, 1'b0);
        checkOutput("t1_count", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) begin
            checkOutput("t1_ch",   32'(obs_q[0].ch),    32'd1);
            checkOutput("t1_old",  32'(obs_q[0].old_v), 32'd0);
            checkOutput("t1_new",  32'(obs_q[0].new_v), 32'd1);
            checkOutput("t1_time", 32'(obs_q[0].tm),    32'd10);
        end

        // Simultaneous changes on all channels, twice.
        doReset();
        cur = '0;
        for (int k = 0; k < 2; k++) applyStimulus(cur, 4'hF, 1'b1, 1'b0);
        for (int r = 0; r < 2; r++) begin
            obs_q.delete();
            cur = (r == 0) ? 8'h55 : 8'hAA;
            for (int k = 0; k < 7; k++) applyStimulus(cur, 4'hF, 1'b1, 1'b0);
            checkOutput($sformatf("t2_count%0d", r), 32'(obs_q.size()), 32'd4);
            for (int k = 0; k < obs_q.size() && k < 4; k++)
                checkOutput($sformatf("t2_order%0d_%0d", r, k), 32'(obs_q[k].ch), 32'(k));
        end

        // Backpressure: channel 2 coalesces 0->1->3 behind a held channel-1 event.
        doReset();
        cur = '0;
        for (int k = 0; k < 2; k++) applyStimulus(cur, 4'hF, 1'b0, 1'b0);
        obs_q.delete();
        cur = withCh(cur, 1, 1);
        applyStimulus(cur, 4'hF, 1'b0, 1'b0);
        tfirst = m_ts;
        cur = withCh(cur, 2, 1);
        applyStimulus(cur, 4'hF, 1'b0, 1'b0);
        cur = withCh(cur, 2, 3);
        for (int k = 0; k < 4; k++) applyStimulus(cur, 4'hF, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(cur, 4'hF, 1'b1, 1'b0);
        checkOutput("t3_count", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() > 1) begin
            checkOutput("t3_ch",   32'(obs_q[1].ch),    32'd2);
            checkOutput("t3_old",  32'(obs_q[1].old_v), 32'd0);
            checkOutput("t3_new",  32'(obs_q[1].new_v), 32'd3);
            checkOutput("t3_time", 32'(obs_q[1].tm),    32'(tfirst));
        end
        checkOutput("t3_ovf2_set", 32'(ovf[2]), 32'd1);
        applyStimulus(cur, 4'hF, 1'b1, 1'b1);
        checkOutput("t3_ovf2_clr", 32'(ovf[2]), 32'd0);

        // Masked change, unmask with the same value, then a real change.
        obs_q.delete();
        cur = withCh(cur, 0, 2);
        for (int k = 0; k < 3; k++) applyStimulus(cur, 4'hE, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(cur, 4'hF, 1'b1, 1'b0);
        checkOutput("t4_none", 32'(obs_q.size()), 32'd0);
        cur = withCh(cur, 0, 1);
        for (int k = 0; k < 4; k++) applyStimulus(cur, 4'hF, 1'b1, 1'b0);
        checkOutput("t4_count", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) begin
            checkOutput("t4_ch",  32'(obs_q[0].ch),    32'd0);
            checkOutput("t4_old", 32'(obs_q[0].old_v), 32'd2);
        end

        // Channel 3 changes again on the edge its event is accepted.
        obs_q.delete();
        cur = withCh(cur, 3, 2);
        applyStimulus(cur, 4'hF, 1'b1, 1'b0);
        applyStimulus(cur, 4'hF, 1'b1, 1'b0);
        cur = withCh(cur, 3, 1);
        for (int k = 0; k < 5; k++) applyStimulus(cur, 4'hF, 1'b1, 1'b0);
        checkOutput("t5_count", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() > 1) begin
            checkOutput("t5_first_new", 32'(obs_q[0].new_v), 32'd2);
            checkOutput("t5_second_old", 32'(obs_q[1].old_v), 32'd2);
            checkOutput("t5_second_new", 32'(obs_q[1].new_v), 32'd1);
        end
        checkOutput("t5_ovf3", 32'(ovf[3]), 32'd0);

        // Reset while an event is shown and three are pending.
        cur = 8'hE7;
        for (int k = 0; k < 3; k++) applyStimulus(cur, 4'hF, 1'b0, 1'b0);
        checkOutput("t6_valid_before", 32'(evt_if.evt_valid), 32'd1);
        cur = 8'h9D;
        mask = 4'hB;
        ch_data = cur;
        ch_mask = mask;
        doReset();
        obs_q.delete();
        for (int k = 0; k < 8; k++) applyStimulus(cur, mask, 1'b1, 1'b0);
`ifdef CES_INIT_EVENT_EN
        exp_cnt = 3;
`else
        exp_cnt = 0;
`endif
        checkOutput("t6_after_reset", 32'(obs_q.size()), 32'(exp_cnt));

        // Random traffic with backpressure, masking and overflow clears.
        doReset();
        cur  = '0;
        mask = 4'hF;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < N_CH; i++)
                if ($urandom_range(0, 3) == 0) cur = withCh(cur, i, int'($urandom_range(0, 3)));
            if (k % 16 == 0) mask = N_CH'($urandom);
            applyStimulus(cur, mask, logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
